// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Width of the bit counter for a given word width; the counter only needs
  // to reach WIDTH-1. Words are at least 2 bits, so this is always >= 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter. Takes one word per valid/ready handshake
// and shifts it out one bit per clock; on the last bit of a word a new word can
// be accepted so consecutive words stream with no idle cycle between them.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic last_bit;
  logic accept;

  // Terminal-count decode and handshake; load_ready comes from registered
  // state only, so accept has no path from inputs to outputs.
  always_comb begin
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_BIT);
    accept   = load_valid && load_ready;
  end

  // State, shift register and bit counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: stay in SHIFT across word boundaries when a new word
  // is accepted on the last bit, otherwise fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift toward the output end with zero fill
  // mid-word, clear when the last bit leaves without a follow-on word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shift_q[WIDTH-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
          shift_d = load_data;
          cnt_d   = '0;
        end else begin
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    load_ready   = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        serial_valid = 1'b1;
        serial_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        frame_start  = (cnt_q == '0);
        done         = last_bit;
        load_ready   = last_bit;
      end
      default: ;
    endcase
  end

endmodule
